ex_muldiv_unit: RTL
===================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded mul/div opcode and the forwarded operands and owns the architectural HI/LO registers.
- Asserts a stall to the hazard/PC logic while a multi-cycle operation is in flight.
- Serves MTHI/MTLO writes and MFHI/MFLO reads in a single cycle.

Parameters:
XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  EX-stage instruction is valid, i.e. not a bubble
op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 NONE
flush  in  1  squash the current EX instruction; it is not accepted
src_a  in  XLEN  rs operand (forwarded)
src_b  in  XLEN  rt operand (forwarded)
stall  out  1  hold IF/ID and ID/EX, insert bubble into EX/MEM (combinational)
busy  out  1  state != IDLE (registered)
done  out  1  one-cycle pulse when HI/LO are updated by a MULT/DIV op
hi  out  XLEN  HI register
lo  out  XLEN  LO register
mf_data  out  XLEN  op==MFHI ? hi : lo (combinational)

Behaviour:
- Reset: synchronous on the rising clk edge with reset high; it overrides all other inputs.
  - Sets state=IDLE, hi=0, lo=0, done=0, busy=0, and clears the iteration counter and datapath registers.
  - Reset mid-operation aborts the operation and leaves HI/LO at 0.
- accept = op_valid & ~flush & ~stall.
- stall = busy & op_valid & ~flush & (op in 1..8). Any mul/div/move instruction waits for the in-flight operation. NONE/other ops never stall.
- States: IDLE, MUL, DIV, FIX.
- IDLE, on accept:
  - MULT/MULTU: latch |a| and |b| (unsigned ops: raw values), record result sign = a[XLEN-1]^b[XLEN-1] (signed only), counter=0, go to MUL.
  - DIV/DIVU: latch magnitudes, record quotient sign = a^b MSB and remainder sign = a MSB (signed only), partial remainder=0, counter=0, go to DIV.
  - MTHI: hi<=src_a next edge; stay IDLE. MTLO: lo<=src_a next edge; stay IDLE.
  - MFHI/MFLO: no state change; mf_data valid the same cycle.
- MUL: one shift-add step per cycle over a 2*XLEN product register; XLEN cycles, then FIX.
- DIV: one restoring step per cycle (shift, trial-subtract, set quotient bit); XLEN cycles, then FIX.
- FIX: apply sign correction (two's-complement negate of product / quotient / remainder as recorded).
  - Write hi/lo on the FIX->IDLE edge. done=1 in the following cycle only.
- Latency: accept at edge E0, busy=1 for XLEN+1 cycles (MUL/DIV XLEN, FIX 1), hi/lo valid and busy=0 after edge E0+XLEN+1. A stalled MF* issues in that cycle and reads the new value.
- Multiply result: hi:lo = full 2*XLEN product, signed or unsigned.
- Division by zero (either signedness): lo=all-ones, hi=src_a as latched (raw, no sign fix). No exception.
- Signed overflow: -2^(XLEN-1)/-1 gives lo=0x80000000, hi=0.
- Flush:
  - Squashes only the instruction presented that cycle; nothing is accepted and stall is deasserted.
  - An operation already in MUL/DIV/FIX is not aborted by flush.
- HI/LO are written only by MT* accept, FIX completion, and reset. op_valid=0 or op=NONE leaves all state unchanged.
- A new op presented in the same cycle as the FIX->IDLE edge is stalled (busy still 1). It is accepted the next cycle.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> busy=1 for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
- DIVU 100/7 -> lo=14, hi=2; DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678 after 33 cycles; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULT then MFLO on the next cycle -> stall=1 for 33 cycles. MFLO then reads the new lo with stall=0. An ADD (op=NONE) during busy -> stall=0.
- MTHI 0xCAFEBABE in IDLE -> hi=0xCAFEBABE next cycle, busy stays 0. MFHI the cycle after -> mf_data=0xCAFEBABE.
- Flush with DIV presented -> no accept, busy stays 0. Reset asserted 10 cycles into a MULT -> next cycle state IDLE, hi=lo=0, busy=0, done=0.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage handshake between the pipeline and the mul/div unit.
//   master (pipeline side): op_valid, op, flush, src_a, src_b -> unit
//   slave  (mul/div unit) : stall, busy, done, hi, lo, mf_data -> pipeline
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            op_valid;
  logic [3:0]      op;
  logic            flush;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mf_data;

  modport master (
    output op_valid, op, flush, src_a, src_b,
    input  stall, busy, done, hi, lo, mf_data
  );

  modport slave (
    input  op_valid, op, flush, src_a, src_b,
    output stall, busy, done, hi, lo, mf_data
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ex_muldiv_if.slave
//           in : op_valid, op, flush, src_a, src_b
//           out: stall (comb), busy, done, hi, lo, mf_data (comb)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no operation in flight; MT*/MF* served, MULT/DIV launched
// S_MUL  | one shift-add step per cycle, XLEN cycles
// S_DIV  | one restoring-division step per cycle, XLEN cycles
// S_FIX  | sign correction; HI/LO written on the exit edge
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, remaining dividend bits / quotient bits}
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   opb_q;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rawa_q;    // unmodified dividend for divide-by-zero
  logic              neg_q;     // product / quotient sign
  logic              rneg_q;    // remainder sign
  logic              div0_q;
  logic              is_div_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              done_q, busy_q;

  logic              is_md_op, stall, accept, op_signed;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_prod_d, div_prod_d, prod_neg;
  logic [XLEN-1:0]   fix_hi_d, fix_lo_d;

  always_comb begin
    is_md_op  = (bus.op >= OP_MULT) && (bus.op <= OP_MFLO);
    stall     = busy_q & bus.op_valid & ~bus.flush & is_md_op;
    accept    = bus.op_valid & ~bus.flush & ~stall;
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    mag_a     = (op_signed && bus.src_a[XLEN-1]) ? -bus.src_a : bus.src_a;
    mag_b     = (op_signed && bus.src_b[XLEN-1]) ? -bus.src_b : bus.src_b;

    // Shift-add: add the multiplicand when the current multiplier LSB is set,
    // keep the carry, then shift the whole product register right by one.
    mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    mul_prod_d = {mul_sum, prod_q[XLEN-1:1]};

    // Restoring step on the left-shifted remainder; a non-negative difference
    // is kept and a 1 enters the quotient at the LSB.
    div_diff = prod_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (!div_diff[XLEN]) div_prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    else                 div_prod_d = {prod_q[2*XLEN-2:0], 1'b0};

    prod_neg = -prod_q;
    fix_hi_d = neg_q ? prod_neg[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    fix_lo_d = neg_q ? prod_neg[XLEN-1:0] : prod_q[XLEN-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        fix_hi_d = rawa_q;
        fix_lo_d = '1;
      end else begin
        fix_hi_d = rneg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        fix_lo_d = neg_q  ? -prod_q[XLEN-1:0]      : prod_q[XLEN-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opb_q    <= '0;
      rawa_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                prod_q   <= {{XLEN{1'b0}}, mag_a};
                opb_q    <= mag_b;
                rawa_q   <= bus.src_a;
                neg_q    <= op_signed & (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
                rneg_q   <= op_signed & bus.src_a[XLEN-1];
                div0_q   <= (bus.src_b == '0);
                is_div_q <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? S_DIV : S_MUL;
              end
              OP_MTHI: hi_q <= bus.src_a;
              OP_MTLO: lo_q <= bus.src_a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          prod_q <= (state_q == S_MUL) ? mul_prod_d : div_prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall   = stall;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = (bus.op == OP_MFHI) ? hi_q : lo_q;
endmodule
